// File: rtl/btb_update_pkg.sv
// Shared types for the BTB update queue: one queued update is a {pc, target} pair.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif

package btb_update_pkg;

   localparam int BTB_ADDR_W = `ADDR_WIDTH;

   typedef struct packed {
      logic [BTB_ADDR_W-1:0] pc;
      logic [BTB_ADDR_W-1:0] target;
   } btb_upd_t;

endpackage

// File: rtl/btb_update_match.sv
// PC lookup across all queue entries; the entry leaving this cycle is masked out.
module btb_update_match #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 26
) (
   input  logic [DEPTH-1:0]                 valid_i,
   input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] pcs_i,
   input  logic [ADDR_WIDTH-1:0]            lookup_pc_i,
   input  logic [DEPTH-1:0]                 pop_mask_i,
   output logic [DEPTH-1:0]                 hit_vec_o,
   output logic                             hit_o
);

   always_comb begin
      hit_vec_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec_o[i] = valid_i[i] & ~pop_mask_i[i] & (pcs_i[i] == lookup_pc_i);
      end
   end

   assign hit_o = |hit_vec_o;

endmodule

// File: rtl/btb_update_queue.sv
// BTB writer: filters resolved branches, coalesces by PC into a small FIFO, and
// drains it to the BTB write port. EX is never stalled; overflow drops are counted.
module btb_update_queue
   import btb_update_pkg::*;
#(
   parameter int ADDR_WIDTH = BTB_ADDR_W,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_res_valid,
   input  logic [ADDR_WIDTH-1:0] i_res_pc,
   input  logic [ADDR_WIDTH-1:0] i_res_target,
   input  logic                  i_res_taken,
   input  logic                  i_res_btb_hit,
   input  logic [ADDR_WIDTH-1:0] i_res_pred_tgt,
   input  logic                  i_flush,
   output logic                  o_btb_valid,
   output logic [ADDR_WIDTH-1:0] o_btb_pc,
   output logic [ADDR_WIDTH-1:0] o_btb_target,
   input  logic                  i_btb_ready,
   output logic                  o_full,
   output logic [CNT_WIDTH-1:0]  o_drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   btb_upd_t              entries_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;
   ptr_t                  head_q;
   ptr_t                  tail_q;
   cnt_t                  count_q;
   logic [CNT_WIDTH-1:0]  drop_cnt_q;

   logic                            upd;
   logic                            pop;
   logic                            coalesce;
   logic                            enq;
   logic                            drop;
   logic                            q_full;
   logic [DEPTH-1:0]                pop_mask;
   logic [DEPTH-1:0]                hit_vec;
   logic                            hit;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_pcs;

   assign upd = i_res_valid & i_res_taken &
                (~i_res_btb_hit | (i_res_pred_tgt != i_res_target));

   assign o_btb_valid  = valid_q[head_q];
   assign o_btb_pc     = entries_q[head_q].pc;
   assign o_btb_target = entries_q[head_q].target;
   assign pop          = o_btb_valid & i_btb_ready;
   assign q_full       = (count_q == cnt_t'(DEPTH));

   always_comb begin
      pop_mask = '0;
      if (pop) pop_mask[head_q] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         entry_pcs[i] = entries_q[i].pc;
      end
   end

   btb_update_match #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_match (
      .valid_i     (valid_q),
      .pcs_i       (entry_pcs),
      .lookup_pc_i (i_res_pc),
      .pop_mask_i  (pop_mask),
      .hit_vec_o   (hit_vec),
      .hit_o       (hit)
   );

   assign coalesce = upd & hit;
   assign enq      = upd & ~hit & (~q_full | pop);
   assign drop     = upd & ~hit & q_full & ~pop;

   // Pop is applied before enqueue so a full-queue pop+push on the same slot leaves it valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else if (i_flush) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + ptr_t'(1);
         end
         if (coalesce) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (hit_vec[i]) entries_q[i].target <= i_res_target;
            end
         end
         if (enq) begin
            entries_q[tail_q].pc     <= i_res_pc;
            entries_q[tail_q].target <= i_res_target;
            valid_q[tail_q]          <= 1'b1;
            tail_q                   <= tail_q + ptr_t'(1);
         end
         if (enq && !pop) begin
            count_q <= count_q + cnt_t'(1);
         end else if (pop && !enq) begin
            count_q <= count_q - cnt_t'(1);
         end
         if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   assign o_full       = q_full;
   assign o_drop_count = drop_cnt_q;

endmodule
